branch_predictor_bht: RTL and testbench

//  Parametrised branch history table: ENTRIES saturating counters, indexed by PC, give pcsrc_p in decode.

---
 rtl/bp_pkg.sv | 26 ++
 rtl/bp_sat_ctr.sv | 26 ++
 rtl/branch_predictor_bht.sv | 79 +++++++
 tb/tb_branch_predictor_bht.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared predictor definitions: 2-bit counter state names, reset value and the saturating step.
// Every predictor block imports this package so counters train identically everywhere.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] CTR_RESET_VAL = WNT;

    // Weakly-not-taken for any counter width: just below the taken threshold.
    function automatic int unsigned ctr_reset_val(input int unsigned ctr_w);
        return (32'd1 << (ctr_w - 32'd1)) - 32'd1;
    endfunction

    function automatic int unsigned sat_step(input int unsigned ctr, input logic taken,
                                             input int unsigned ctr_w);
        int unsigned ctr_max;
        ctr_max = (32'd1 << ctr_w) - 32'd1;
        if (taken)
            return (ctr == ctr_max) ? ctr : ctr + 32'd1;
        return (ctr == 32'd0) ? ctr : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// One saturating predictor counter; trains on the clock edge when enabled, async reset to weakly-not-taken.
// Latency: one cycle from enable to new value. No backpressure: every enabled edge is applied.
// Inputs are registered only through the counter itself; output is the current state.
module bp_sat_ctr
    import bp_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             taken,
    output logic [CTR_W-1:0] ctr
);

    localparam logic [CTR_W-1:0] RST_VAL = (CTR_W == 2) ? CTR_W'(CTR_RESET_VAL)
                                                        : CTR_W'(ctr_reset_val(CTR_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ctr <= RST_VAL;
        else if (en)
            ctr <= CTR_W'(sat_step(32'(ctr), taken, CTR_W));
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Branch history table: PC-indexed saturating counters predict taken in decode, trained by execute.
// Latency: lookup is combinational; updates and stats land on the next clk edge. No backpressure.
// Build option BHT_GSHARE_EN hashes the index with a resolve-time global history register.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6,
    parameter int CTR_W   = 2,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch,
    input  logic [PC_W-1:0]   pc_lookup,
    output logic              pcsrc_p,
    output logic [IDX_W-1:0]  pred_idx,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_taken,
    input  logic              upd_mispred,
    output logic [PERF_W-1:0] stat_lookups,
    output logic [PERF_W-1:0] stat_mispred
);

    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    logic [IDX_W-1:0] pc_idx;
    logic [CTR_W-1:0] ctr_q [ENTRIES];
    logic             unused_pc;

    assign pc_idx    = pc_lookup[IDX_W+1:2];
    assign unused_pc = ^{pc_lookup[PC_W-1:IDX_W+2], pc_lookup[1:0]};

`ifdef BHT_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    // History advances only on resolved branches, so no recovery is needed on mispredicts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ghr <= '0;
        else if (upd_valid)
            ghr <= {ghr[IDX_W-2:0], upd_taken};
    end

    assign pred_idx = pc_idx ^ ghr;
`else
    assign pred_idx = pc_idx;
`endif

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
        bp_sat_ctr #(
            .CTR_W (CTR_W)
        ) u_ctr (
            .clk   (clk),
            .rst   (rst),
            .en    (upd_valid && (upd_idx == IDX_W'(i))),
            .taken (upd_taken),
            .ctr   (ctr_q[i])
        );
    end

    // Read sees the registered value, so a same-index update shows up only next cycle.
    assign pcsrc_p = branch & ctr_q[pred_idx][CTR_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lookups <= '0;
            stat_mispred <= '0;
        end else begin
            if (branch && (stat_lookups != PERF_MAX))
                stat_lookups <= stat_lookups + PERF_W'(1);
            if (upd_valid && upd_mispred && (stat_mispred != PERF_MAX))
                stat_mispred <= stat_mispred + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht: directed scenarios plus randomized traffic vs a model.
// Build with or without BHT_GSHARE_EN; the model follows the same define.
module tb_branch_predictor_bht;

    localparam int PC_W     = 32;
    localparam int ENTRIES  = 64;
    localparam int IDX_W    = 6;
    localparam int CTR_W    = 2;
    localparam int PERF_W   = 8;
    localparam int CTR_MAX  = 3;
    localparam int PERF_MAX = 255;

    logic              clk = 1'b0;
    logic              rst;
    logic              branch;
    logic [PC_W-1:0]   pc_lookup;
    logic              pcsrc_p;
    logic [IDX_W-1:0]  pred_idx;
    logic              upd_valid;
    logic [IDX_W-1:0]  upd_idx;
    logic              upd_taken;
    logic              upd_mispred;
    logic [PERF_W-1:0] stat_lookups;
    logic [PERF_W-1:0] stat_mispred;

    int total = 0;
    int bad   = 0;

    int ctr_m [ENTRIES];
    int ghr_m;
    int lookups_m;
    int mispred_m;

    branch_predictor_bht #(
        .PC_W    (PC_W),
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .CTR_W   (CTR_W),
        .PERF_W  (PERF_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .branch       (branch),
        .pc_lookup    (pc_lookup),
        .pcsrc_p      (pcsrc_p),
        .pred_idx     (pred_idx),
        .upd_valid    (upd_valid),
        .upd_idx      (upd_idx),
        .upd_taken    (upd_taken),
        .upd_mispred  (upd_mispred),
        .stat_lookups (stat_lookups),
        .stat_mispred (stat_mispred)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) ctr_m[i] = 1;
        ghr_m     = 0;
        lookups_m = 0;
        mispred_m = 0;
    endfunction

    function automatic int exp_idx(input logic [PC_W-1:0] pc);
        return (int'(pc / 4) % ENTRIES) ^ ghr_m;
    endfunction

    function automatic logic exp_pred(input logic b, input logic [PC_W-1:0] pc);
        return b && (ctr_m[exp_idx(pc)] >= 2);
    endfunction

    // A random PC whose lookup lands on table entry t under the current history.
    function automatic logic [PC_W-1:0] pc_for(input int t);
        logic [PC_W-1:0] r;
        r      = $urandom;
        r[7:2] = 6'((t ^ ghr_m) % ENTRIES);
        return r;
    endfunction

    task automatic drive(input logic b, input logic [PC_W-1:0] pc, input logic uv,
                         input logic [IDX_W-1:0] ui, input logic ut, input logic um);
        branch      = b;
        pc_lookup   = pc;
        upd_valid   = uv;
        upd_idx     = ui;
        upd_taken   = ut;
        upd_mispred = um;
        #1;
    endtask

    // Advance one edge and apply the architectural effects of the inputs seen at it.
    task automatic tick();
        @(posedge clk);
        if (branch && lookups_m < PERF_MAX) lookups_m++;
        if (upd_valid) begin
            if (upd_mispred && mispred_m < PERF_MAX) mispred_m++;
            if (upd_taken) ctr_m[upd_idx] = (ctr_m[upd_idx] < CTR_MAX) ? ctr_m[upd_idx] + 1 : CTR_MAX;
            else           ctr_m[upd_idx] = (ctr_m[upd_idx] > 0) ? ctr_m[upd_idx] - 1 : 0;
`ifdef BHT_GSHARE_EN
            ghr_m = ((ghr_m * 2) + int'(upd_taken)) % ENTRIES;
`endif
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0000_0014, 1'b0, '0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        total++;
        if (pcsrc_p !== 1'b0) begin
            bad++; $display("FAIL reset_pcsrc: got %b want 0", pcsrc_p);
        end
        total++;
        if (stat_lookups !== '0 || stat_mispred !== '0) begin
            bad++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_lookups, stat_mispred);
        end
        rst = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            drive(1'b1, pc_for(i), 1'b0, '0, 1'b0, 1'b0);
            total++;
            if (pcsrc_p !== exp_pred(1'b1, pc_lookup) || pred_idx !== IDX_W'(exp_idx(pc_lookup))) begin
                bad++; $display("FAIL reset_lookup[%0d]: got p=%b idx=%0d want p=0 idx=%0d",
                                i, pcsrc_p, pred_idx, exp_idx(pc_lookup));
            end
            tick();
            total++;
            if (stat_lookups !== PERF_W'(lookups_m)) begin
                bad++; $display("FAIL reset_lookups_cnt[%0d]: got %0d want %0d", i, stat_lookups, lookups_m);
            end
        end
    endtask

    task automatic test_hysteresis();
        logic taken_seq [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic want_seq  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, $urandom, 1'b1, 6'd5, taken_seq[k], 1'b0);
            tick();
            drive(1'b1, pc_for(5), 1'b0, '0, 1'b0, 1'b0);
            total++;
            if (pcsrc_p !== want_seq[k] || pred_idx !== IDX_W'(exp_idx(pc_lookup))) begin
                bad++; $display("FAIL hysteresis[%0d]: got p=%b idx=%0d want p=%b", k, pcsrc_p, pred_idx, want_seq[k]);
            end
            tick();
        end
    endtask

    task automatic test_saturate_low();
        logic taken_seq [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic want_seq  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, $urandom, 1'b1, 6'd9, taken_seq[k], 1'b1);
            tick();
            drive(1'b1, pc_for(9), 1'b0, '0, 1'b0, 1'b0);
            total++;
            if (pcsrc_p !== want_seq[k]) begin
                bad++; $display("FAIL saturate_low[%0d]: got %b want %b", k, pcsrc_p, want_seq[k]);
            end
            tick();
        end
        total++;
        if (stat_mispred !== PERF_W'(mispred_m)) begin
            bad++; $display("FAIL saturate_low_mispred: got %0d want %0d", stat_mispred, mispred_m);
        end
    endtask

    task automatic test_collision();
        drive(1'b1, pc_for(3), 1'b1, 6'd3, 1'b1, 1'b0);
        total++;
        if (pcsrc_p !== 1'b0) begin
            bad++; $display("FAIL collision_same_cycle: got %b want 0", pcsrc_p);
        end
        tick();
        drive(1'b1, pc_for(3), 1'b0, '0, 1'b0, 1'b0);
        total++;
        if (pcsrc_p !== 1'b1) begin
            bad++; $display("FAIL collision_next_cycle: got %b want 1", pcsrc_p);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        drive(1'b1, pc_for(3), 1'b0, '0, 1'b0, 1'b0);
        total++;
        if (pcsrc_p !== 1'b1) begin
            bad++; $display("FAIL mid_reset_before: got %b want 1", pcsrc_p);
        end
        rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (pcsrc_p !== 1'b0 || stat_lookups !== '0 || stat_mispred !== '0) begin
            bad++; $display("FAIL mid_reset_clear: got p=%b lk=%0d mp=%0d want 0/0/0",
                            pcsrc_p, stat_lookups, stat_mispred);
        end
        total++;
        if (pred_idx !== IDX_W'(exp_idx(pc_lookup))) begin
            bad++; $display("FAIL mid_reset_idx: got %0d want %0d", pred_idx, exp_idx(pc_lookup));
        end
        rst = 1'b0;
        drive(1'b0, $urandom, 1'b1, 6'd3, 1'b1, 1'b1);
        tick();
        drive(1'b1, pc_for(3), 1'b0, '0, 1'b0, 1'b0);
        total++;
        if (pcsrc_p !== 1'b1 || stat_mispred !== 8'd1 || stat_lookups !== 8'd0) begin
            bad++; $display("FAIL mid_reset_after: got p=%b mp=%0d lk=%0d want 1/1/0",
                            pcsrc_p, stat_mispred, stat_lookups);
        end
        tick();
    endtask

    task automatic test_gshare();
        logic [IDX_W-1:0] want;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        drive(1'b0, $urandom, 1'b1, 6'd20, 1'b1, 1'b0); tick();
        drive(1'b0, $urandom, 1'b1, 6'd21, 1'b1, 1'b0); tick();
        drive(1'b0, $urandom, 1'b1, 6'd22, 1'b0, 1'b0); tick();
`ifdef BHT_GSHARE_EN
        want = 6'd22;
`else
        want = 6'd16;
`endif
        drive(1'b0, 32'h0000_0040, 1'b0, '0, 1'b0, 1'b0);
        total++;
        if (pred_idx !== want) begin
            bad++; $display("FAIL gshare_idx: got %0d want %0d", pred_idx, want);
        end
        total++;
        if (pcsrc_p !== 1'b0) begin
            bad++; $display("FAIL gshare_nobranch: got %b want 0", pcsrc_p);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            total++;
            if (pcsrc_p !== exp_pred(branch, pc_lookup) || pred_idx !== IDX_W'(exp_idx(pc_lookup))) begin
                bad++; $display("FAIL random_lookup[%0d]: got p=%b idx=%0d want p=%b idx=%0d", n,
                                pcsrc_p, pred_idx, exp_pred(branch, pc_lookup), exp_idx(pc_lookup));
            end
            tick();
            total++;
            if (stat_lookups !== PERF_W'(lookups_m) || stat_mispred !== PERF_W'(mispred_m)) begin
                bad++; $display("FAIL random_stats[%0d]: got %0d/%0d want %0d/%0d", n,
                                stat_lookups, stat_mispred, lookups_m, mispred_m);
            end
        end
    endtask

    task automatic test_stat_saturation();
        for (int n = 0; n < 300; n++) begin
            drive(1'b1, $urandom, 1'b1, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'b1);
            tick();
        end
        total++;
        if (stat_lookups !== PERF_W'(PERF_MAX) || stat_mispred !== PERF_W'(PERF_MAX)) begin
            bad++; $display("FAIL stat_saturation: got %0d/%0d want %0d/%0d",
                            stat_lookups, stat_mispred, PERF_MAX, PERF_MAX);
        end
        drive(1'b1, pc_for(int'($urandom_range(0, 63))), 1'b0, '0, 1'b0, 1'b0);
        total++;
        if (pcsrc_p !== exp_pred(1'b1, pc_lookup)) begin
            bad++; $display("FAIL stat_saturation_pred: got %b want %b", pcsrc_p, exp_pred(1'b1, pc_lookup));
        end
    endtask

    initial begin
        test_reset();
        test_hysteresis();
        test_saturate_low();
        test_collision();
        test_mid_reset();
        test_gshare();
        test_random();
        test_stat_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
